// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for the fetch stage.
// Serves one word fetch at a time over valid/ready. The word comes back a
// fixed LATENCY edges after the accept edge, together with its PC.
// Misaligned and out-of-range PCs return ERR_INST with resp_err set.
// A loader port writes the program image in any state.
module imem_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] ERR_INST  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_inst,
  output logic [31:0]       resp_addr,
  output logic              resp_err,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              busy
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [31:0] DEPTH32  = 32'(DEPTH);
  localparam logic [2:0]  CNT_INIT = 3'(LATENCY - 1);

  // Reject unsupported configurations at elaboration time.
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("imem_responder: LATENCY must be in 1..4");
  end
  if (ADDR_W < 1 || ADDR_W > 30) begin : g_bad_addr_w
    $error("imem_responder: ADDR_W must be in 1..30");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [2:0]        cnt;
  logic [2:0]        cnt_nx;
  logic [31:0]       addr_q;
  logic              accept;
  logic              enter_resp;
  logic [31:0]       look_addr;
  logic [31:0]       look_off;
  logic              look_err;
  logic [ADDR_W-1:0] look_idx;
  logic [31:0]       mem [DEPTH];

  // A new request may be taken when idle, or when the current response is
  // being consumed this cycle; flush always blocks acceptance.
  assign req_ready  = ~flush & ((state == S_IDLE) | ((state == S_RESP) & resp_ready));
  assign accept     = req_valid & req_ready;
  assign resp_valid = (state == S_RESP);
  assign busy       = (state != S_IDLE);

  // Address that feeds the array on the edge entering RESP: the live request
  // for a single-cycle fetch, the latched PC when coming out of WAIT.
  assign look_addr = (state == S_WAIT) ? addr_q : req_addr;
  assign look_off  = look_addr - BASE_ADDR;
  assign look_err  = (look_addr[1:0] != 2'b00) |
                     (look_addr < BASE_ADDR) |
                     ((look_off >> 2) >= DEPTH32);
  assign look_idx  = look_off[ADDR_W+1:2];

  // Next-state and wait-counter logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_nx   = state;
    cnt_nx     = cnt;
    enter_resp = 1'b0;
    if (flush) begin
      state_nx = S_IDLE;
      cnt_nx   = 3'd0;
    end else begin
      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            if (LATENCY > 1) begin
              state_nx = S_WAIT;
              cnt_nx   = CNT_INIT;
            end else begin
              state_nx   = S_RESP;
              enter_resp = 1'b1;
            end
          end else if ((state == S_RESP) && resp_ready) begin
            state_nx = S_IDLE;
          end
        end
        S_WAIT: begin
          cnt_nx = cnt - 3'd1;
          if (cnt == 3'd1) begin
            state_nx   = S_RESP;
            enter_resp = 1'b1;
          end
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = 3'd0;
        end
      endcase
    end
  end

  // State register and wait counter.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Request PC latch and response registers; the array is sampled on the
  // edge entering RESP, so a same-edge loader write is not yet visible.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q    <= 32'h0;
      resp_inst <= 32'h0;
      resp_addr <= 32'h0;
      resp_err  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
      end
      if (enter_resp) begin
        resp_addr <= look_addr;
        resp_err  <= look_err;
        resp_inst <= look_err ? ERR_INST : mem[look_idx];
      end
    end
  end

  // Program image write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; it is plain storage filled by the loader,
    // and clearing it would only add a wide reset network.
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: self-checking bench for imem_responder.
// Two instances share clock, reset and loader: dut1 with LATENCY=1 and
// dut3 with LATENCY=3. Responses are matched against per-instance queues.
module tb_imem_responder;

  localparam logic [31:0] BASE = 32'h0040_0000;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  logic        flush1, req_valid1, req_ready1, resp_valid1, resp_ready1, resp_err1, busy1;
  logic [31:0] req_addr1, resp_inst1, resp_addr1;
  logic        flush3, req_valid3, req_ready3, resp_valid3, resp_ready3, resp_err3, busy3;
  logic [31:0] req_addr3, resp_inst3, resp_addr3;

  resp_t sb1[$];
  resp_t sb3[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  imem_responder #(
    .ADDR_W(10), .BASE_ADDR(BASE), .LATENCY(1), .ERR_INST(32'h0000_0000)
  ) dut1 (
    .clk(clk), .rstn(rstn), .flush(flush1),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_inst(resp_inst1),
    .resp_addr(resp_addr1), .resp_err(resp_err1),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy1)
  );

  imem_responder #(
    .ADDR_W(10), .BASE_ADDR(BASE), .LATENCY(3), .ERR_INST(32'h0000_0000)
  ) dut3 (
    .clk(clk), .rstn(rstn), .flush(flush3),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_inst(resp_inst3),
    .resp_addr(resp_addr3), .resp_err(resp_err3),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic resp_t mk(input logic [31:0] inst, input logic [31:0] addr, input logic err);
    resp_t r;
    r.inst = inst;
    r.addr = addr;
    r.err  = err;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_we   = 1'b0;
  endtask

  // Scoreboard for dut1: every consumed response must match the oldest entry.
  always @(negedge clk) begin
    if (rstn && resp_valid1 && resp_ready1) begin
      if (sb1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb1_unexpected: got response for %h, required none", resp_addr1);
      end else begin
        resp_t e;
        e = sb1.pop_front();
        check("sb1_inst", resp_inst1, e.inst);
        check("sb1_addr", resp_addr1, e.addr);
        check("sb1_err", {31'b0, resp_err1}, {31'b0, e.err});
      end
    end
  end

  // Scoreboard for dut3.
  always @(negedge clk) begin
    if (rstn && resp_valid3 && resp_ready3) begin
      if (sb3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb3_unexpected: got response for %h, required none", resp_addr3);
      end else begin
        resp_t e;
        e = sb3.pop_front();
        check("sb3_inst", resp_inst3, e.inst);
        check("sb3_addr", resp_addr3, e.addr);
        check("sb3_err", {31'b0, resp_err3}, {31'b0, e.err});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[9];
    vt[0] = '{addr: 32'h0040_0000, inst: 32'h2408_0005, err: 1'b0};
    vt[1] = '{addr: 32'h0040_0004, inst: 32'h1111_1111, err: 1'b0};
    vt[2] = '{addr: 32'h0040_0008, inst: 32'h2222_2222, err: 1'b0};
    vt[3] = '{addr: 32'h0040_0002, inst: 32'h0000_0000, err: 1'b1};
    vt[4] = '{addr: 32'h0040_1000, inst: 32'h0000_0000, err: 1'b1};
    vt[5] = '{addr: 32'h0040_0FFC, inst: 32'hDEAD_BEEF, err: 1'b0};
    vt[6] = '{addr: 32'h003F_FFFC, inst: 32'h0000_0000, err: 1'b1};
    vt[7] = '{addr: 32'h0040_000C, inst: 32'h3333_3333, err: 1'b0};
    vt[8] = '{addr: 32'hFFFF_FFFC, inst: 32'h0000_0000, err: 1'b1};

    rstn = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    flush1 = 1'b0; req_valid1 = 1'b0; req_addr1 = '0; resp_ready1 = 1'b1;
    flush3 = 1'b0; req_valid3 = 1'b0; req_addr3 = '0; resp_ready3 = 1'b1;

    // Reset state.
    #12;
    check("rst_resp_valid1", resp_valid1, 0);
    check("rst_busy1", busy1, 0);
    check("rst_resp_inst1", resp_inst1, 0);
    check("rst_resp_addr1", resp_addr1, 0);
    check("rst_resp_err1", resp_err1, 0);
    check("rst_req_ready1", req_ready1, 1);
    check("rst_resp_valid3", resp_valid3, 0);
    check("rst_busy3", busy3, 0);
    rstn = 1'b1;
    step();

    // Program image.
    load(10'd0, 32'h2408_0005);
    load(10'd1, 32'h1111_1111);
    load(10'd2, 32'h2222_2222);
    load(10'd3, 32'h3333_3333);
    load(10'd1023, 32'hDEAD_BEEF);

    // Back-to-back stream on dut1: one word per cycle, errors included.
    for (int i = 0; i < 9; i++) begin
      req_valid1 = 1'b1;
      req_addr1  = vt[i].addr;
      @(negedge clk);
      if (i > 0) check("b2b_resp_valid", resp_valid1, 1);
      check("b2b_req_ready", req_ready1, 1);
      sb1.push_back(mk(vt[i].inst, vt[i].addr, vt[i].err));
      step();
    end
    req_valid1 = 1'b0;
    @(negedge clk);
    check("b2b_last_valid", resp_valid1, 1);
    step();
    @(negedge clk);
    check("b2b_idle_valid", resp_valid1, 0);
    check("b2b_idle_busy", busy1, 0);
    check("b2b_sb1_empty", sb1.size(), 0);
    step();

    // Backpressure: response held stable while resp_ready is low.
    resp_ready1 = 1'b0;
    req_valid1  = 1'b1;
    req_addr1   = 32'h0040_0008;
    @(negedge clk);
    check("hold_req_ready", req_ready1, 1);
    sb1.push_back(mk(32'h2222_2222, 32'h0040_0008, 1'b0));
    step();
    req_addr1 = 32'h0040_000C;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hold_resp_valid", resp_valid1, 1);
      check("hold_resp_inst", resp_inst1, 32'h2222_2222);
      check("hold_resp_addr", resp_addr1, 32'h0040_0008);
      check("hold_req_ready_low", req_ready1, 0);
      step();
    end
    req_valid1  = 1'b0;
    resp_ready1 = 1'b1;
    step();
    @(negedge clk);
    check("hold_release_valid", resp_valid1, 0);
    check("hold_release_busy", busy1, 0);
    step();

    // Flush discards an unconsumed response.
    resp_ready1 = 1'b0;
    req_valid1  = 1'b1;
    req_addr1   = 32'h0040_0000;
    @(negedge clk);
    check("fl1_req_ready", req_ready1, 1);
    step();
    req_valid1 = 1'b0;
    @(negedge clk);
    check("fl1_resp_present", resp_valid1, 1);
    step();
    flush1 = 1'b1;
    step();
    flush1 = 1'b0;
    @(negedge clk);
    check("fl1_resp_dropped", resp_valid1, 0);
    check("fl1_busy", busy1, 0);
    step();
    resp_ready1 = 1'b1;
    step();

    // LATENCY=3: response exactly three edges after accept, busy meanwhile.
    req_valid3 = 1'b1;
    req_addr3  = 32'h0040_0004;
    @(negedge clk);
    check("lat3_req_ready", req_ready3, 1);
    sb3.push_back(mk(32'h1111_1111, 32'h0040_0004, 1'b0));
    step();
    req_valid3 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("lat3_wait_valid", resp_valid3, 0);
      check("lat3_wait_busy", busy3, 1);
      step();
    end
    @(negedge clk);
    check("lat3_resp_valid", resp_valid3, 1);
    step();
    @(negedge clk);
    check("lat3_idle_busy", busy3, 0);
    check("lat3_sb3_empty", sb3.size(), 0);
    step();

    // Flush during WAIT: no response follows.
    req_valid3 = 1'b1;
    req_addr3  = 32'h0040_0008;
    @(negedge clk);
    check("fl3_req_ready", req_ready3, 1);
    step();
    req_valid3 = 1'b0;
    @(negedge clk);
    check("fl3_wait_busy", busy3, 1);
    step();
    flush3 = 1'b1;
    step();
    flush3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("fl3_no_resp", resp_valid3, 0);
      check("fl3_idle_busy", busy3, 0);
      step();
    end

    // Request presented together with flush is refused.
    flush3     = 1'b1;
    req_valid3 = 1'b1;
    req_addr3  = 32'h0040_000C;
    @(negedge clk);
    check("fl3_req_blocked", req_ready3, 0);
    step();
    flush3     = 1'b0;
    req_valid3 = 1'b0;
    @(negedge clk);
    check("fl3_not_accepted", busy3, 0);
    step();

    // A normal request still works after the flushes.
    req_valid3 = 1'b1;
    req_addr3  = 32'h0040_000C;
    @(negedge clk);
    check("post_fl3_req_ready", req_ready3, 1);
    sb3.push_back(mk(32'h3333_3333, 32'h0040_000C, 1'b0));
    step();
    req_valid3 = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check("post_fl3_sb3_empty", sb3.size(), 0);
    step();

    // Loader write on the RESP-entry edge: old data, then new data.
    req_valid1 = 1'b1;
    req_addr1  = 32'h0040_0004;
    ld_we      = 1'b1;
    ld_addr    = 10'd1;
    ld_data    = 32'hAAAA_5555;
    @(negedge clk);
    check("rbw_req_ready", req_ready1, 1);
    sb1.push_back(mk(32'h1111_1111, 32'h0040_0004, 1'b0));
    step();
    ld_we = 1'b0;
    @(negedge clk);
    check("rbw_req_ready2", req_ready1, 1);
    sb1.push_back(mk(32'hAAAA_5555, 32'h0040_0004, 1'b0));
    step();
    req_valid1 = 1'b0;
    step();
    @(negedge clk);
    check("rbw_sb1_empty", sb1.size(), 0);
    step();

    // Reset in the middle of a request: nothing comes out afterwards.
    req_valid3 = 1'b1;
    req_addr3  = 32'h0040_0000;
    @(negedge clk);
    check("rst_mid_req_ready", req_ready3, 1);
    step();
    req_valid3 = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy3, 0);
    #2;
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rst_mid_no_resp", resp_valid3, 0);
    end
    step();

    // Array contents survive reset.
    req_valid1 = 1'b1;
    req_addr1  = 32'h0040_0000;
    @(negedge clk);
    check("post_rst_req_ready", req_ready1, 1);
    sb1.push_back(mk(32'h2408_0005, 32'h0040_0000, 1'b0));
    step();
    req_valid1 = 1'b0;
    repeat (2) step();

    @(negedge clk);
    check("final_sb1_empty", sb1.size(), 0);
    check("final_sb3_empty", sb3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
